// File: rtl/branch_target_buffer_pkg.sv
// Shared BTB constants: index/tag geometry, 2-bit counter encodings and
// the layout of the predicted-PC/counter field carried in the IF/ID register.
package branch_target_buffer_pkg;

  localparam int BTB_ENTRIES_DEFAULT = 16;
  localparam int BTB_ADDR_W          = 32;
  localparam int BTB_WORD_LSB        = 2;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  localparam int IFID_PPC_LSB = 0;
  localparam int IFID_PPC_MSB = 31;
  localparam int IFID_CB_LSB  = 32;
  localparam int IFID_CB_MSB  = 33;
  localparam int IFID_PPCCB_W = 34;

  function automatic int btb_idx_w(input int entries);
    return $clog2(entries);
  endfunction

  function automatic int btb_tag_w(input int entries);
    return BTB_ADDR_W - BTB_WORD_LSB - $clog2(entries);
  endfunction

endpackage

// File: rtl/branch_target_buffer_sat_counter2.sv
// Two-bit saturating direction counter: next state for one resolved branch.
module sat_counter2
  import branch_target_buffer_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       taken,
  output logic [1:0] nxt
);

  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic t);
    logic [1:0] r;
    r = c;
    if (t) begin
      if (c != CNT_ST) r = c + 2'd1;
    end else begin
      if (c != CNT_SNT) r = c - 2'd1;
    end
    return r;
  endfunction

  assign nxt = sat_step(cur, taken);

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC,
// single-cycle training/allocation from resolved branches in Execute.
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int ENTRIES = BTB_ENTRIES_DEFAULT
)
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] PC,
  output logic [31:0] Predict,
  output logic [1:0]  CB,
  output logic        Hit,
  input  logic        WriteEnable,
  input  logic [31:0] JmpInstrAddr,
  input  logic [31:0] JmpAddr,
  input  logic        Taken,
  input  logic        Invalidate
);

  localparam int IDX_W = btb_idx_w(ENTRIES);
  localparam int TAG_W = btb_tag_w(ENTRIES);

  logic [ENTRIES-1:0] valid_q;
  logic [1:0]         cnt_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];

  logic [IDX_W-1:0] look_idx;
  logic [TAG_W-1:0] look_tag;
  logic             look_hit;
  logic [1:0]       look_cnt;

  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_en;
  logic             upd_hit;
  logic             upd_alloc;
  logic             upd_train;
  logic             upd_retarget;
  logic [1:0]       cnt_nxt;

  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, PC[1:0], JmpInstrAddr[1:0]};

  // Lookup path: reads pre-edge table contents only, no update bypass.
  assign look_idx = PC[IDX_W+1:2];
  assign look_tag = PC[31:IDX_W+2];
  assign look_hit = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
  assign look_cnt = cnt_q[look_idx];

  assign Hit     = look_hit;
  assign CB      = look_hit ? look_cnt : CNT_WNT;
  assign Predict = (look_hit && look_cnt[1]) ? target_q[look_idx] : (PC + 32'd4);

  // Update path: Invalidate suppresses any concurrent training or allocation.
  assign upd_idx      = JmpInstrAddr[IDX_W+1:2];
  assign upd_tag      = JmpInstrAddr[31:IDX_W+2];
  assign upd_en       = WriteEnable && !Invalidate;
  assign upd_hit      = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_train    = upd_en && upd_hit;
  assign upd_alloc    = upd_en && !upd_hit && Taken;
  assign upd_retarget = upd_alloc || (upd_train && Taken);

  sat_counter2 u_sat_counter2 (
    .cur   (cnt_q[upd_idx]),
    .taken (Taken),
    .nxt   (cnt_nxt)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_q[i] <= CNT_WNT;
      end
    end else if (Invalidate) begin
      valid_q <= '0;
    end else begin
      if (upd_alloc) begin
        valid_q[upd_idx] <= 1'b1;
        cnt_q[upd_idx]   <= CNT_WT;
      end
      if (upd_train) begin
        cnt_q[upd_idx] <= cnt_nxt;
      end
    end
  end

  // Tags and targets are only meaningful behind a set valid bit, so no reset.
  always_ff @(posedge Clk) begin
    if (upd_alloc) begin
      tag_q[upd_idx] <= upd_tag;
    end
    if (upd_retarget) begin
      target_q[upd_idx] <= JmpAddr;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Bench for branch_target_buffer: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against an address-keyed model.
module tb_branch_target_buffer;

  localparam int ENTRIES = 16;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [31:0] PC = 32'h0000_0100;
  logic [31:0] Predict;
  logic [1:0]  CB;
  logic        Hit;
  logic        WriteEnable = 1'b0;
  logic [31:0] JmpInstrAddr = 32'h0;
  logic [31:0] JmpAddr = 32'h0;
  logic        Taken = 1'b0;
  logic        Invalidate = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  branch_target_buffer #(.ENTRIES(ENTRIES)) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .PC           (PC),
    .Predict      (Predict),
    .CB           (CB),
    .Hit          (Hit),
    .WriteEnable  (WriteEnable),
    .JmpInstrAddr (JmpInstrAddr),
    .JmpAddr      (JmpAddr),
    .Taken        (Taken),
    .Invalidate   (Invalidate)
  );

  // Model: each slot remembers which branch word address owns it.
  bit          m_valid [ENTRIES];
  int unsigned m_owner [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_cnt   [ENTRIES];

  function automatic int unsigned slot_of(input logic [31:0] a);
    return (a >> 2) % ENTRIES;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_cnt[i]   = 1;
    end
  endfunction

  function automatic void model_look(input logic [31:0] pc, output bit hit,
                                     output logic [1:0] cb, output logic [31:0] pred);
    int unsigned s;
    s    = slot_of(pc);
    hit  = m_valid[s] && (m_owner[s] == (pc >> 2));
    cb   = hit ? 2'(m_cnt[s]) : 2'b01;
    pred = (hit && m_cnt[s] >= 2) ? m_tgt[s] : pc + 32'd4;
  endfunction

  function automatic void model_update(input bit we, input bit inv, input logic [31:0] jia,
                                       input logic [31:0] ja, input bit tk);
    int unsigned s;
    bit hit;
    if (inv) begin
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    end else if (we) begin
      s   = slot_of(jia);
      hit = m_valid[s] && (m_owner[s] == (jia >> 2));
      if (hit && tk) begin
        m_cnt[s] = (m_cnt[s] == 3) ? 3 : m_cnt[s] + 1;
        m_tgt[s] = ja;
      end else if (hit) begin
        m_cnt[s] = (m_cnt[s] == 0) ? 0 : m_cnt[s] - 1;
      end else if (tk) begin
        m_valid[s] = 1'b1;
        m_owner[s] = jia >> 2;
        m_tgt[s]   = ja;
        m_cnt[s]   = 2;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge Clk) begin
    if (!Rst) model_update(WriteEnable, Invalidate, JmpInstrAddr, JmpAddr, Taken);
  end

  always @(negedge Clk) begin
    bit          eh;
    logic [1:0]  ecb;
    logic [31:0] ep;
    model_look(PC, eh, ecb, ep);
    chk("model_hit", {31'b0, Hit}, {31'b0, eh});
    chk("model_cb", {30'b0, CB}, {30'b0, ecb});
    chk("model_predict", Predict, ep);
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic look(input string name, input logic [31:0] pc, input logic eh,
                      input logic [1:0] ecb, input logic [31:0] ep);
    PC = pc;
    #1;
    chk({name, "_hit"}, {31'b0, Hit}, {31'b0, eh});
    chk({name, "_cb"}, {30'b0, CB}, {30'b0, ecb});
    chk({name, "_predict"}, Predict, ep);
  endtask

  task automatic drive_upd(input logic [31:0] jia, input logic [31:0] ja, input logic tk);
    WriteEnable  = 1'b1;
    JmpInstrAddr = jia;
    JmpAddr      = ja;
    Taken        = tk;
  endtask

  initial begin
    model_reset();
    #1;
    look("in_reset", 32'h0000_0100, 1'b0, 2'b01, 32'h0000_0104);
    step();
    Rst = 1'b0;
    look("after_reset", 32'h0000_0100, 1'b0, 2'b01, 32'h0000_0104);

    // Allocation: same-cycle lookup still sees the old (empty) entry.
    step();
    drive_upd(32'h0000_0100, 32'h0000_0400, 1'b1);
    look("same_cycle_old", 32'h0000_0100, 1'b0, 2'b01, 32'h0000_0104);
    step();
    WriteEnable = 1'b0;
    look("alloc", 32'h0000_0100, 1'b1, 2'b10, 32'h0000_0400);

    // Three back-to-back not-taken updates walk the counter down.
    step();
    drive_upd(32'h0000_0100, 32'h0000_0999, 1'b0);
    look("nt0", 32'h0000_0100, 1'b1, 2'b10, 32'h0000_0400);
    step();
    look("nt1", 32'h0000_0100, 1'b1, 2'b01, 32'h0000_0104);
    step();
    look("nt2", 32'h0000_0100, 1'b1, 2'b00, 32'h0000_0104);
    step();
    WriteEnable = 1'b0;
    look("nt3", 32'h0000_0100, 1'b1, 2'b00, 32'h0000_0104);

    // Aliasing: 0x140 maps to the same slot and evicts 0x100.
    step();
    drive_upd(32'h0000_0140, 32'h0000_0800, 1'b1);
    step();
    WriteEnable = 1'b0;
    look("alias_old", 32'h0000_0100, 1'b0, 2'b01, 32'h0000_0104);
    look("alias_new", 32'h0000_0140, 1'b1, 2'b10, 32'h0000_0800);

    // Invalidate wins over a concurrent allocation.
    step();
    drive_upd(32'h0000_0200, 32'h0000_0300, 1'b1);
    Invalidate = 1'b1;
    step();
    WriteEnable = 1'b0;
    Invalidate  = 1'b0;
    look("inv_140", 32'h0000_0140, 1'b0, 2'b01, 32'h0000_0144);
    look("inv_200", 32'h0000_0200, 1'b0, 2'b01, 32'h0000_0204);
    for (int k = 0; k < ENTRIES; k++) begin
      PC = 32'h0000_0100 + 32'(4 * k);
      #1;
      chk("inv_sweep_hit", {31'b0, Hit}, 32'h0);
    end

    step();
    look("wrap", 32'hFFFF_FFFC, 1'b0, 2'b01, 32'h0000_0000);

    // Asynchronous reset pulse between edges clears hits immediately.
    step();
    drive_upd(32'h0000_0100, 32'h0000_0400, 1'b1);
    step();
    WriteEnable = 1'b0;
    look("pre_rst", 32'h0000_0100, 1'b1, 2'b10, 32'h0000_0400);
    Rst = 1'b1;
    model_reset();
    look("mid_rst", 32'h0000_0100, 1'b0, 2'b01, 32'h0000_0104);
    Rst = 1'b0;

    // Randomized traffic over a small address pool to provoke hits and aliasing.
    for (int n = 0; n < 600; n++) begin
      step();
      PC = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 19)) << 2)
           | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) PC = 32'hFFFF_FFFC;
      WriteEnable  = ($urandom_range(0, 1) == 1);
      JmpInstrAddr = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 19)) << 2)
                     | 32'($urandom_range(0, 3));
      JmpAddr      = $urandom;
      Taken        = ($urandom_range(0, 2) != 0);
      Invalidate   = ($urandom_range(0, 59) == 0);
    end
    step();
    WriteEnable = 1'b0;
    Invalidate  = 1'b0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
